// File: rtl/roi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : roi_pkg
// Brief    : Shared FSM state, default widths and ROI record for the crop block
// Revision : 1.0
// ============================================================================
package roi_pkg;

    localparam int c_pix_w      = 24;
    localparam int c_hor_w      = 11;
    localparam int c_ver_w      = 9;
    localparam int c_fifo_depth = 4;
    localparam int c_frame_w    = 1280;
    localparam int c_frame_h    = 480;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_CROP    = 2'd2
    } roi_state_t;

    typedef struct packed {
        logic [c_hor_w-1:0] hmin;
        logic [c_hor_w-1:0] hmax;
        logic [c_ver_w-1:0] vmin;
        logic [c_ver_w-1:0] vmax;
    } roi_t;

    function automatic int roi_bits(input int hor_w, input int ver_w);
        return 2 * hor_w + 2 * ver_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/roi_fifo.sv
`default_nettype none
// ============================================================================
// Module   : roi_fifo
// Brief    : Synchronous first-word-fall-through FIFO holding pending ROIs
// Revision : 1.0
// ============================================================================
module roi_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_aw+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/roi_stream_crop.sv
`default_nettype none
// ============================================================================
// Module   : roi_stream_crop
// Brief    : Queues ROI requests and crops one video frame per ROI.
//            Define ROI_CLAMP_EN to clamp out-of-frame max bounds instead of
//            rejecting the ROI.
// Revision : 1.0
// ============================================================================
module roi_stream_crop
    import roi_pkg::*;
#(
    parameter int PIX_W      = c_pix_w,
    parameter int HOR_W      = c_hor_w,
    parameter int VER_W      = c_ver_w,
    parameter int FIFO_DEPTH = c_fifo_depth,
    parameter int FRAME_W    = c_frame_w,
    parameter int FRAME_H    = c_frame_h
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [HOR_W-1:0] HorMinIn,
    input  logic [HOR_W-1:0] HorMaxIn,
    input  logic [VER_W-1:0] VerMinIn,
    input  logic [VER_W-1:0] VerMaxIn,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             de_in,
    input  logic             vsync_in,
    input  logic             ready_in,
    output logic             valid_out,
    output logic [PIX_W-1:0] pixel_out,
    output logic             de_out,
    output logic             vsync_out,
    output logic             done,
    output logic [HOR_W-1:0] OutWidth,
    output logic [VER_W-1:0] OutHeight,
    output logic             frame_req,
    output logic             roi_err
);

    localparam int               c_roi_w      = roi_bits(HOR_W, VER_W);
    localparam logic [HOR_W:0]   c_frame_w_x  = (HOR_W+1)'(FRAME_W);
    localparam logic [VER_W:0]   c_frame_h_x  = (VER_W+1)'(FRAME_H);
    localparam logic [HOR_W-1:0] c_hor_last   = HOR_W'(FRAME_W - 1);
    localparam logic [VER_W-1:0] c_ver_last   = VER_W'(FRAME_H - 1);

    typedef struct packed {
        logic [HOR_W-1:0] hmin;
        logic [HOR_W-1:0] hmax;
        logic [VER_W-1:0] vmin;
        logic [VER_W-1:0] vmax;
    } roi_rec_t;

    roi_state_t       r_state;
    roi_state_t       w_state_nxt;
    roi_rec_t         r_roi;
    roi_rec_t         w_head;
    roi_rec_t         w_fifo_din;
    logic [HOR_W-1:0] w_hmax_adj;
    logic [VER_W-1:0] w_vmax_adj;
    logic             w_roi_ok;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_crop_start;
    logic             w_crop_end;
    logic             w_in_roi;
    logic             w_vs_rise;
    logic             w_de_fall;
    logic             r_alive;
    logic             r_de_d;
    logic             r_vs_d;
    logic [HOR_W-1:0] r_col;
    logic [VER_W-1:0] r_row;
    logic [HOR_W-1:0] r_out_w;
    logic [VER_W-1:0] r_out_h;
    logic [PIX_W-1:0] r_pix_out;
    logic             r_de_out;
    logic             r_vs_out;
    logic             r_done;
    logic             r_err;

`ifdef ROI_CLAMP_EN
    assign w_hmax_adj = ({1'b0, HorMaxIn} >= c_frame_w_x) ? c_hor_last : HorMaxIn;
    assign w_vmax_adj = ({1'b0, VerMaxIn} >= c_frame_h_x) ? c_ver_last : VerMaxIn;
`else
    assign w_hmax_adj = HorMaxIn;
    assign w_vmax_adj = VerMaxIn;
`endif

    // The max-bound range test only bites when clamping is disabled.
    assign w_roi_ok = ({1'b0, HorMinIn}   < c_frame_w_x) &&
                      ({1'b0, w_hmax_adj} < c_frame_w_x) &&
                      ({1'b0, VerMinIn}   < c_frame_h_x) &&
                      ({1'b0, w_vmax_adj} < c_frame_h_x) &&
                      (HorMinIn <= w_hmax_adj) &&
                      (VerMinIn <= w_vmax_adj);

    assign ready_out  = r_alive && !w_fifo_full;
    assign w_accept   = valid_in && ready_out;
    assign w_push     = w_accept && w_roi_ok;
    assign w_fifo_din = '{hmin: HorMinIn, hmax: w_hmax_adj, vmin: VerMinIn, vmax: w_vmax_adj};

    roi_fifo #(
        .WIDTH (c_roi_w),
        .DEPTH (FIFO_DEPTH)
    ) u_roi_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (w_fifo_din),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_vs_rise = vsync_in && !r_vs_d;
    assign w_de_fall = !de_in && r_de_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_de_d <= 1'b0;
            r_vs_d <= 1'b0;
            r_col  <= '0;
            r_row  <= '0;
        end else begin
            r_de_d <= de_in;
            r_vs_d <= vsync_in;
            if (w_vs_rise) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_de_fall) begin
                r_col <= '0;
                r_row <= r_row + VER_W'(1);
            end else if (de_in) begin
                r_col <= r_col + HOR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_crop_start = 1'b0;
        w_crop_end   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_WAIT_VS;
                end
            end
            ST_WAIT_VS: begin
                // A frame starting while downstream is busy is simply skipped.
                if (w_vs_rise && ready_in) begin
                    w_crop_start = 1'b1;
                    w_state_nxt  = ST_CROP;
                end
            end
            ST_CROP: begin
                if (w_vs_rise || (w_de_fall && (r_row == r_roi.vmax))) begin
                    w_crop_end  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_in_roi = (r_state == ST_CROP) && de_in &&
                      (r_col >= r_roi.hmin) && (r_col <= r_roi.hmax) &&
                      (r_row >= r_roi.vmin) && (r_row <= r_roi.vmax);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alive   <= 1'b0;
            r_roi     <= '0;
            r_out_w   <= '0;
            r_out_h   <= '0;
            r_pix_out <= '0;
            r_de_out  <= 1'b0;
            r_vs_out  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_alive   <= 1'b1;
            r_err     <= w_accept && !w_roi_ok;
            r_vs_out  <= w_crop_start;
            r_done    <= w_crop_end;
            r_de_out  <= w_in_roi;
            r_pix_out <= w_in_roi ? pixel_in : '0;
            if (w_pop) begin
                r_roi   <= w_head;
                r_out_w <= w_head.hmax - w_head.hmin + HOR_W'(1);
                r_out_h <= w_head.vmax - w_head.vmin + VER_W'(1);
            end
        end
    end

    assign valid_out = (r_state == ST_CROP);
    assign frame_req = (r_state == ST_WAIT_VS);
    assign pixel_out = r_pix_out;
    assign de_out    = r_de_out;
    assign vsync_out = r_vs_out;
    assign done      = r_done;
    assign roi_err   = r_err;
    assign OutWidth  = r_out_w;
    assign OutHeight = r_out_h;

endmodule
`default_nettype wire

// File: tb/tb_roi_stream_crop.sv
`default_nettype none
// ============================================================================
// Module   : tb_roi_stream_crop
// Brief    : Self-checking bench: ROI validation table plus frame-level scoreboard
// Revision : 1.0
// ============================================================================
module tb_roi_stream_crop;

    localparam int PIX_W = 24;
    localparam int HOR_W = 11;
    localparam int VER_W = 9;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [HOR_W-1:0] HorMinIn = '0, HorMaxIn = '0;
    logic [VER_W-1:0] VerMinIn = '0, VerMaxIn = '0;
    logic             valid_in = 1'b0;
    logic             ready_out;
    logic [PIX_W-1:0] pixel_in = '0;
    logic             de_in = 1'b0;
    logic             vsync_in = 1'b0;
    logic             ready_in = 1'b1;
    logic             valid_out;
    logic [PIX_W-1:0] pixel_out;
    logic             de_out, vsync_out, done;
    logic [HOR_W-1:0] OutWidth;
    logic [VER_W-1:0] OutHeight;
    logic             frame_req, roi_err;

    always #5 clk = ~clk;

    roi_stream_crop #(
        .PIX_W(PIX_W), .HOR_W(HOR_W), .VER_W(VER_W),
        .FIFO_DEPTH(4), .FRAME_W(1280), .FRAME_H(480)
    ) dut (
        .clk(clk), .reset(reset),
        .HorMinIn(HorMinIn), .HorMaxIn(HorMaxIn), .VerMinIn(VerMinIn), .VerMaxIn(VerMaxIn),
        .valid_in(valid_in), .ready_out(ready_out),
        .pixel_in(pixel_in), .de_in(de_in), .vsync_in(vsync_in), .ready_in(ready_in),
        .valid_out(valid_out), .pixel_out(pixel_out), .de_out(de_out),
        .vsync_out(vsync_out), .done(done),
        .OutWidth(OutWidth), .OutHeight(OutHeight),
        .frame_req(frame_req), .roi_err(roi_err)
    );

    typedef struct packed {
        logic             de;
        logic [PIX_W-1:0] pix;
        logic             valid;
        logic             vs;
        logic             done;
    } exp_t;

    typedef struct {
        int h0, h1, v0, v1;
        bit err;
        int w, h;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_de_seen = 0;
    int   n_done_seen = 0;
    exp_t sb[$];
    bit   m_active = 1'b0;
    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({ready_out, valid_out, de_out, vsync_out, done, frame_req, roi_err,
                    pixel_out, OutWidth, OutHeight});
    endfunction

    // One clock: wait to the falling edge, then score the output produced by
    // the input driven one cycle earlier.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (de_out) n_de_seen++;
        if (done) n_done_seen++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("stream{de,pix,valid,vs,done}",
                  64'({de_out, pixel_out, valid_out, vsync_out, done}), 64'(e));
        end
    endtask

    task automatic drive(input logic vs, input logic de, input logic [PIX_W-1:0] pix, input exp_t e);
        vsync_in = vs;
        de_in    = de;
        pixel_in = pix;
        sb.push_back(e);
        tick();
    endtask

    task automatic drive_frame(input int rows, input int cols, input bit crop,
                               input int h0, input int h1, input int v0, input int v1);
        exp_t e;
        logic [PIX_W-1:0] pix;
        e = '0;
        if (m_active) begin
            e.done   = 1'b1;
            m_active = 1'b0;
        end else if (crop) begin
            e.vs     = 1'b1;
            e.valid  = 1'b1;
            m_active = 1'b1;
        end
        drive(1'b1, 1'b0, '0, e);
        for (int b = 0; b < 2; b++) begin
            e = '0;
            e.valid = m_active;
            drive(1'b0, 1'b0, '0, e);
        end
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                pix     = PIX_W'($urandom());
                e       = '0;
                e.valid = m_active;
                e.de    = m_active && (c >= h0) && (c <= h1) && (r >= v0) && (r <= v1);
                e.pix   = e.de ? pix : '0;
                drive(1'b0, 1'b1, pix, e);
            end
            for (int b = 0; b < 3; b++) begin
                e = '0;
                if (b == 0 && m_active && r == v1) begin
                    e.done   = 1'b1;
                    m_active = 1'b0;
                end
                e.valid = m_active;
                drive(1'b0, 1'b0, '0, e);
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        valid_in = 1'b0;
        de_in    = 1'b0;
        vsync_in = 1'b0;
        ready_in = 1'b1;
        reset    = 1'b1;
        m_active = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic push_roi(input int h0, input int h1, input int v0, input int v1, output bit ok);
        HorMinIn = HOR_W'(h0);
        HorMaxIn = HOR_W'(h1);
        VerMinIn = VER_W'(v0);
        VerMaxIn = VER_W'(v1);
        valid_in = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (ready_out) ok = 1'b1;
            tick();
        end
        valid_in = 1'b0;
    endtask

    task automatic set_vec(input int i, input int h0, input int h1, input int v0, input int v1,
                           input bit err, input int w, input int h);
        tbl[i] = '{h0, h1, v0, v1, err, w, h};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;

        set_vec(0, 100, 227,  50, 113, 1'b0, 128, 64);
        set_vec(1, 300, 200,  10,  20, 1'b1,   0,  0);
        set_vec(2,   0,   0,   0,   0, 1'b0,   1,  1);
        set_vec(3,   0, 1279,  0, 479, 1'b0, 1280, 480);
        set_vec(4,   5,   5,   7,   6, 1'b1,   0,  0);
        set_vec(7,   0,  10, 480, 480, 1'b1,   0,  0);
        set_vec(8, 1280, 1300, 0,   0, 1'b1,   0,  0);
`ifdef ROI_CLAMP_EN
        set_vec(5, 1279, 1280, 0,   0, 1'b0,   1,  1);
        set_vec(6, 1200, 1400, 0,   3, 1'b0,  80,  4);
        set_vec(9,  10,  20, 400, 500, 1'b0,  11, 80);
`else
        set_vec(5, 1279, 1280, 0,   0, 1'b1,   0,  0);
        set_vec(6, 1200, 1400, 0,   3, 1'b1,   0,  0);
        set_vec(9,  10,  20, 400, 500, 1'b1,   0,  0);
`endif

        // Reset state, during and after reset
        @(negedge clk);
        check("outs_in_reset", all_outs(), 64'h0);
        reset = 1'b0;
        tick();
        tick();
        check("outs_after_reset", all_outs(), 64'h1 << 50);

        // ROI validation / size table
        for (int i = 0; i < 10; i++) begin
            apply_reset();
            push_roi(tbl[i].h0, tbl[i].h1, tbl[i].v0, tbl[i].v1, ok);
            check($sformatf("accept[%0d]", i), 64'(ok), 64'h1);
            check($sformatf("roi_err[%0d]", i), 64'(roi_err), 64'(tbl[i].err));
            tick();
            check($sformatf("roi_err_clear[%0d]", i), 64'(roi_err), 64'h0);
            check($sformatf("frame_req[%0d]", i), 64'(frame_req), 64'(!tbl[i].err));
            check($sformatf("OutWidth[%0d]", i), 64'(OutWidth), 64'(tbl[i].w));
            check($sformatf("OutHeight[%0d]", i), 64'(OutHeight), 64'(tbl[i].h));
        end

        // Full-size crop of a 128x64 ROI
        apply_reset();
        push_roi(100, 227, 50, 113, ok);
        tick();
        n_de_seen = 0;
        n_done_seen = 0;
        drive_frame(116, 240, 1'b1, 100, 227, 50, 113);
        check("main_de_count", 64'(n_de_seen), 64'd8192);
        check("main_done_count", 64'(n_done_seen), 64'd1);
        check("main_frame_req_after", 64'(frame_req), 64'h0);

        // vsync during crop aborts with done; the new frame is not cropped
        apply_reset();
        push_roi(0, 1, 2, 10, ok);
        tick();
        drive_frame(4, 3, 1'b1, 0, 1, 2, 10);
        drive_frame(2, 3, 1'b0, 0, 1, 2, 10);
        check("abort_frame_req", 64'(frame_req), 64'h0);

        // Skip a frame while downstream is not ready
        apply_reset();
        push_roi(1, 2, 0, 1, ok);
        tick();
        ready_in = 1'b0;
        drive_frame(3, 4, 1'b0, 1, 2, 0, 1);
        check("skip_frame_req", 64'(frame_req), 64'h1);
        ready_in = 1'b1;
        n_de_seen = 0;
        drive_frame(3, 4, 1'b1, 1, 2, 0, 1);
        check("skip_de_count", 64'(n_de_seen), 64'd4);
        check("skip_frame_req_after", 64'(frame_req), 64'h0);

        // FIFO back-pressure: one ROI held by the FSM, four queued, fifth stalls
        apply_reset();
        push_roi(1, 2, 0, 1, ok);
        tick();
        push_roi(10, 19, 0, 0, ok);
        check("fifo_push1", 64'(ok), 64'h1);
        push_roi(0, 4, 0, 0, ok);
        push_roi(0, 5, 0, 0, ok);
        push_roi(0, 6, 0, 0, ok);
        check("fifo_push4", 64'(ok), 64'h1);
        check("fifo_full_ready", 64'(ready_out), 64'h0);
        HorMinIn = HOR_W'(3);
        HorMaxIn = HOR_W'(7);
        VerMinIn = '0;
        VerMaxIn = '0;
        valid_in = 1'b1;
        repeat (5) tick();
        check("fifo_stall_ready", 64'(ready_out), 64'h0);
        drive_frame(3, 4, 1'b1, 1, 2, 0, 1);
        valid_in = 1'b0;
        check("fifo_refull_ready", 64'(ready_out), 64'h0);
        check("fifo_next_width", 64'(OutWidth), 64'd10);
        check("fifo_next_frame_req", 64'(frame_req), 64'h1);

        // Asynchronous reset in the middle of row 30
        apply_reset();
        push_roi(2, 5, 0, 40, ok);
        tick();
        push_roi(0, 3, 0, 3, ok);
        drive_frame(30, 8, 1'b1, 2, 5, 0, 40);
        for (int c = 0; c < 4; c++) begin
            exp_t e;
            logic [PIX_W-1:0] pix;
            pix     = PIX_W'($urandom());
            e       = '0;
            e.valid = 1'b1;
            e.de    = (c >= 2);
            e.pix   = e.de ? pix : '0;
            drive(1'b0, 1'b1, pix, e);
        end
        check("midcrop_de_before_reset", 64'(de_out), 64'h1);
        #2;
        de_in = 1'b0;
        reset = 1'b1;
        #1;
        check("midcrop_outs_in_reset", all_outs(), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        m_active = 1'b0;
        repeat (4) tick();
        check("midcrop_fifo_empty", 64'(frame_req), 64'h0);
        check("midcrop_ready_after", 64'(ready_out), 64'h1);
        check("midcrop_valid_after", 64'(valid_out), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
